fifo_sram_ctrl: RTL and testbench

FIFO_SRAM_CTRL -- requirements
Module: fifo_sram_ctrl

---
 rtl/fifo_sram_ctrl.sv | 132 +++++++++++++
 tb/tb_fifo_sram_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sram_ctrl.sv
// fifo_sram_ctrl: moves words from a first-word-fall-through FIFO into consecutive
// SRAM addresses, one write handshake per word.
// Optional feature: define FIFO_SRAM_CTRL_TIMEOUT_EN to abandon a write that waits
// 255 cycles for sram_ack, reported by a one-cycle err pulse.
module fifo_sram_ctrl #(
  parameter int unsigned dw = 32,
  parameter int unsigned aw = 10
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [aw-1:0] base_addr,
  input  logic [aw-1:0] length,
  input  logic          empty,
  input  logic [dw-1:0] fifo_data_in,
  output logic          pop,
  output logic [aw-1:0] sram_addr,
  output logic [dw-1:0] sram_data_out,
  output logic          sram_we,
  input  logic          sram_ack,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [aw-1:0] count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [aw-1:0] len_q;
  logic [aw-1:0] count_inc;

  // Word count after the write currently being acknowledged
  assign count_inc = count + aw'(1);

`ifdef FIFO_SRAM_CTRL_TIMEOUT_EN
  localparam int unsigned      TMO_W    = 8;
  // Value held by the counter during the 255th unacknowledged WRITE cycle
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(254);

  logic [TMO_W-1:0] tmo_q;
  logic             err_q;

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Transfer sequencer with registered outputs; abort overrides ack and completion
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state         <= IDLE;
      pop           <= 1'b0;
      sram_we       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      sram_addr     <= '0;
      sram_data_out <= '0;
      count         <= '0;
      len_q         <= '0;
`ifdef FIFO_SRAM_CTRL_TIMEOUT_EN
      tmo_q         <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      pop  <= 1'b0;
      done <= 1'b0;
`ifdef FIFO_SRAM_CTRL_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      if (abort && (state != IDLE)) begin
        state   <= IDLE;
        busy    <= 1'b0;
        sram_we <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              sram_addr <= base_addr;
              count     <= '0;
              len_q     <= length;
              busy      <= 1'b1;
              state     <= (length == '0) ? DONE : FETCH;
            end
          end
          FETCH: begin
            if (!empty) begin
              pop           <= 1'b1;
              sram_data_out <= fifo_data_in;
              sram_we       <= 1'b1;
              state         <= WRITE;
`ifdef FIFO_SRAM_CTRL_TIMEOUT_EN
              tmo_q         <= '0;
`endif
            end
          end
          WRITE: begin
            if (sram_ack) begin
              sram_we   <= 1'b0;
              sram_addr <= sram_addr + aw'(1);
              count     <= count_inc;
              state     <= (count_inc == len_q) ? DONE : FETCH;
            end
`ifdef FIFO_SRAM_CTRL_TIMEOUT_EN
            else if (tmo_q == TMO_LAST) begin
              err_q   <= 1'b1;
              sram_we <= 1'b0;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              tmo_q <= tmo_q + TMO_W'(1);
            end
`endif
          end
          DONE: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_sram_ctrl.sv
// Self-checking bench for fifo_sram_ctrl: transaction-level reference model,
// per-cycle output compare, directed scenarios and a randomized phase.
`timescale 1ns/1ps
module tb_fifo_sram_ctrl;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;
`ifdef FIFO_SRAM_CTRL_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic          wb_clk;
  logic          wb_rst_n;
  logic          start, abort, empty, sram_ack;
  logic [AW-1:0] base_addr, length;
  logic [DW-1:0] fifo_data_in;
  logic          pop, sram_we, busy, done, err;
  logic [AW-1:0] sram_addr, count;
  logic [DW-1:0] sram_data_out;

  fifo_sram_ctrl #(.dw(DW), .aw(AW)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length), .empty(empty),
    .fifo_data_in(fifo_data_in), .pop(pop), .sram_addr(sram_addr),
    .sram_data_out(sram_data_out), .sram_we(sram_we), .sram_ack(sram_ack),
    .busy(busy), .done(done), .err(err), .count(count)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  int n_vec = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus environment ----------------
  logic [DW-1:0] fifo_q[$];
  bit  fill_auto  = 1'b0;
  bit  rand_stall = 1'b0;
  int  ack_mode   = 0;   // 0 ack at once, 1 ack after ack_delay, 2 random, 3 never
  int  ack_delay  = 0;
  int  we_age     = 0;
  int  stall_cnt  = 0;

  // ---------------- monitor / logs ----------------
  int cyc = 0;
  int n_pops, n_done, n_err, n_we_cyc;
  int first_pop_cyc, last_ack_cyc, last_done_cyc, err_cyc, start_cyc;
  logic [AW-1:0] wa_log[$];
  logic [DW-1:0] wd_log[$];

  task automatic clear_logs();
    n_pops = 0; n_done = 0; n_err = 0; n_we_cyc = 0;
    first_pop_cyc = -1; last_ack_cyc = -1; last_done_cyc = -1; err_cyc = -1; start_cyc = -1;
    wa_log.delete(); wd_log.delete();
  endtask

  // FIFO consumption and event logging at each active edge
  initial forever begin
    @(posedge wb_clk);
    cyc++;
    if (wb_rst_n) begin
      if (pop) begin
        n_pops++;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      end
      if (start && !busy) start_cyc = cyc;
      if (sram_we) n_we_cyc++;
      if (sram_we && sram_ack) begin
        wa_log.push_back(sram_addr);
        wd_log.push_back(sram_data_out);
        last_ack_cyc = cyc;
      end
      if (done) begin n_done++; last_done_cyc = cyc; end
      if (err)  begin n_err++;  err_cyc = cyc;       end
    end
  end

  // ---------------- reference model ----------------
  // Transfer described as: active flag, a word in flight, a pending completion.
  logic          m_busy = 1'b0, m_pending = 1'b0, m_finishing = 1'b0;
  logic          m_pop = 1'b0, m_done = 1'b0, m_err = 1'b0;
  logic [AW-1:0] m_addr = '0, m_count = '0, m_len = '0;
  logic [DW-1:0] m_data = '0;
  int            m_wait = 0;

  initial forever begin
    @(posedge wb_clk or negedge wb_rst_n);
    if (!wb_rst_n) begin
      m_busy = 1'b0; m_pending = 1'b0; m_finishing = 1'b0;
      m_pop = 1'b0; m_done = 1'b0; m_err = 1'b0;
      m_addr = '0; m_count = '0; m_len = '0; m_data = '0; m_wait = 0;
    end else begin
      m_pop = 1'b0; m_done = 1'b0; m_err = 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_addr = base_addr; m_count = '0; m_len = length;
          m_busy = 1'b1; m_finishing = (length == '0);
        end
      end else if (abort) begin
        m_busy = 1'b0; m_pending = 1'b0; m_finishing = 1'b0;
      end else if (m_finishing) begin
        m_finishing = 1'b0; m_busy = 1'b0; m_done = 1'b1;
      end else if (!m_pending) begin
        if (!empty) begin
          m_pending = 1'b1; m_pop = 1'b1; m_data = fifo_data_in; m_wait = 0;
        end
      end else if (sram_ack) begin
        m_pending = 1'b0;
        m_addr    = m_addr + AW'(1);
        m_count   = m_count + AW'(1);
        if (m_count == m_len) m_finishing = 1'b1;
      end else begin
        m_wait++;
        if (TMO && (m_wait == 255)) begin
          m_err = 1'b1; m_pending = 1'b0; m_busy = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model
  initial forever begin
    @(negedge wb_clk);
    if (cmp_en) begin
      check("pop",           32'(pop),           32'(m_pop));
      check("sram_we",       32'(sram_we),       32'(m_pending));
      check("busy",          32'(busy),          32'(m_busy));
      check("done",          32'(done),          32'(m_done));
      check("err",           32'(err),           32'(m_err));
      check("sram_addr",     32'(sram_addr),     32'(m_addr));
      check("sram_data_out", 32'(sram_data_out), 32'(m_data));
      check("count",         32'(count),         32'(m_count));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(negedge wb_clk);
    start     = 1'b0;
    abort     = 1'b0;
    base_addr = AW'($urandom);
    length    = AW'($urandom);
    if (fill_auto) while (fifo_q.size() < 4) fifo_q.push_back(DW'($urandom));
    we_age = sram_we ? we_age + 1 : 0;
    case (ack_mode)
      0:       sram_ack = sram_we;
      1:       sram_ack = sram_we && (we_age > ack_delay);
      2:       sram_ack = 1'($urandom_range(0, 1));
      default: sram_ack = 1'b0;
    endcase
    empty = (fifo_q.size() == 0) || (stall_cnt > 0) ||
            (rand_stall && ($urandom_range(0, 3) == 0));
    if (stall_cnt > 0) stall_cnt--;
    fifo_data_in = (fifo_q.size() > 0) ? fifo_q[0] : DW'(32'hDEAD_BEEF);
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] l);
    next_cycle();
    start = 1'b1; base_addr = b; length = l;
  endtask

  task automatic settle(input int n);
    repeat (n) next_cycle();
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      next_cycle();
      if (!busy) break;
    end
    check("busy_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    start = 1'b0; abort = 1'b0; base_addr = '0; length = '0;
    empty = 1'b1; fifo_data_in = '0; sram_ack = 1'b0;
    clear_logs();
    // Asynchronous reset before any clock edge
    wb_rst_n = 1'b1;
    #1 wb_rst_n = 1'b0;
    #1;
    check("rst_pop",  32'(pop),           32'd0);
    check("rst_we",   32'(sram_we),       32'd0);
    check("rst_busy", 32'(busy),          32'd0);
    check("rst_done", 32'(done),          32'd0);
    check("rst_err",  32'(err),           32'd0);
    check("rst_addr", 32'(sram_addr),     32'd0);
    check("rst_data", 32'(sram_data_out), 32'd0);
    check("rst_cnt",  32'(count),         32'd0);
    repeat (3) @(negedge wb_clk);
    wb_rst_n = 1'b1;
    cmp_en   = 1'b1;

    // Four words from 0x010 at full throughput
    clear_logs(); fifo_q.delete();
    for (int i = 0; i < 4; i++) fifo_q.push_back(32'hA000_0000 + 32'(i));
    fill_auto = 1'b0; ack_mode = 0;
    do_start(10'h010, 10'd4);
    wait_idle(60); settle(2);
    check("t1_pops", 32'(n_pops), 32'd4);
    check("t1_nwr",  32'(wa_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t1_addr", 32'(wa_log[i]), 32'h10 + 32'(i));
      check("t1_data", 32'(wd_log[i]), 32'hA000_0000 + 32'(i));
    end
    check("t1_done",   32'(n_done), 32'd1);
    check("t1_done_t", 32'(last_done_cyc - last_ack_cyc), 32'd2);
    check("t1_rate",   32'(last_ack_cyc - first_pop_cyc), 32'd6);
    check("t1_count",  32'(count), 32'd4);

    // Address wrap at the top of the SRAM
    clear_logs(); fill_auto = 1'b1;
    do_start(10'h3FE, 10'd3);
    wait_idle(60); settle(2);
    check("t2_nwr",   32'(wa_log.size()), 32'd3);
    check("t2_addr0", 32'(wa_log[0]), 32'h3FE);
    check("t2_addr1", 32'(wa_log[1]), 32'h3FF);
    check("t2_addr2", 32'(wa_log[2]), 32'h000);
    check("t2_done",  32'(n_done), 32'd1);

    // Empty FIFO for 10 FETCH cycles, ack 5 cycles late
    clear_logs(); fill_auto = 1'b0; fifo_q.delete();
    for (int i = 0; i < 3; i++) fifo_q.push_back(32'hC0DE_0000 + 32'(i));
    ack_mode = 1; ack_delay = 5; stall_cnt = 11;
    do_start(10'h100, 10'd3);
    wait_idle(200); settle(2);
    check("t3_pops",   32'(n_pops), 32'd3);
    check("t3_first",  32'(first_pop_cyc - start_cyc), 32'd12);
    check("t3_wecyc",  32'(n_we_cyc), 32'd18);
    check("t3_data2",  32'(wd_log[2]), 32'hC0DE_0002);
    check("t3_done",   32'(n_done), 32'd1);

    // Abort together with the second ack; a start while busy is ignored
    clear_logs(); fill_auto = 1'b1; ack_mode = 0;
    do_start(10'h200, 10'd4);
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      if (i == 2) begin start = 1'b1; base_addr = 10'h300; length = 10'd2; end
      if (sram_we && (wa_log.size() == 1)) begin abort = 1'b1; break; end
    end
    wait_idle(10); settle(4);
    check("t4_nwr",   32'(wa_log.size()), 32'd2);
    check("t4_addr0", 32'(wa_log[0]), 32'h200);
    check("t4_addr1", 32'(wa_log[1]), 32'h201);
    check("t4_done",  32'(n_done), 32'd0);
    check("t4_busy",  32'(busy), 32'd0);
    check("t4_count", 32'(count), 32'd1);
    check("t4_pops",  32'(n_pops), 32'd2);

    // Zero-length transfer
    clear_logs();
    do_start(10'h055, 10'd0);
    wait_idle(10); settle(2);
    check("t5_done",   32'(n_done), 32'd1);
    check("t5_done_t", 32'(last_done_cyc - start_cyc), 32'd2);
    check("t5_pops",   32'(n_pops), 32'd0);
    check("t5_wecyc",  32'(n_we_cyc), 32'd0);
    check("t5_count",  32'(count), 32'd0);

    // SRAM never acknowledges
    clear_logs(); ack_mode = 3;
    do_start(10'h020, 10'd1);
`ifdef FIFO_SRAM_CTRL_TIMEOUT_EN
    wait_idle(400); settle(2);
    check("t6_err",   32'(n_err), 32'd1);
    check("t6_err_t", 32'(err_cyc - first_pop_cyc), 32'd255);
    check("t6_done",  32'(n_done), 32'd0);
    check("t6_we",    32'(sram_we), 32'd0);
`else
    settle(300);
    check("t6_err",  32'(n_err), 32'd0);
    check("t6_we",   32'(sram_we), 32'd1);
    check("t6_busy", 32'(busy), 32'd1);
    next_cycle(); abort = 1'b1;
    wait_idle(5);
`endif

    // Reset in the middle of a transfer
    clear_logs(); ack_mode = 2;
    do_start(10'h040, 10'd6);
    settle(5);
    #2 wb_rst_n = 1'b0;
    #1;
    check("t7_pop",  32'(pop),           32'd0);
    check("t7_we",   32'(sram_we),       32'd0);
    check("t7_busy", 32'(busy),          32'd0);
    check("t7_addr", 32'(sram_addr),     32'd0);
    check("t7_data", 32'(sram_data_out), 32'd0);
    check("t7_cnt",  32'(count),         32'd0);
    @(negedge wb_clk);
    wb_rst_n = 1'b1;
    clear_logs();
    settle(10);
    check("t7_nodone", 32'(n_done), 32'd0);
    check("t7_idle",   32'(busy), 32'd0);

    // Randomized traffic: random starts, stalls, acks and aborts
    clear_logs(); rand_stall = 1'b1; ack_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      if ($urandom_range(0, 7) == 0) begin
        start     = 1'b1;
        base_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(1020, 1023)) : AW'($urandom);
        length    = AW'($urandom_range(0, 5));
      end
      if ($urandom_range(0, 63) == 0) abort = 1'b1;
    end
    rand_stall = 1'b0; ack_mode = 0;
    wait_idle(50); settle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
